t07_wb_mem_bridge: RTL and testbench
====================================

Name: t07_wb_mem_bridge

Overview:
- Responder for the MMIO block's instruction/data-memory request port.
- Accepts rwi/address/write-data requests from MMIO and runs single Wishbone classic-cycle transactions to external instruction/data memory.
- Returns read data (ExtData) and the busy handshake that MMIO forwards to the CPU memory handler.
- Includes a bus timeout, so a stalled slave cannot hang the CPU.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in BUS before abort; legal range 1 to 65535.
- ERR_DATA, 32'hDEADBEEF: read data returned on timeout.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- rwi_in  input  2  request from MMIO: 01 write, 10 read, 00/11 idle
- addr_in  input  32  byte address from MMIO, already remapped
- writeData_in  input  32  write data from MMIO
- busy_o  output  1  transaction in progress, to MMIO busy_o
- ExtData_out  output  32  read data, to MMIO ExtData_in
- timeout_err  output  1  sticky flag: a bus timeout has occurred
- CYC_O  output  1  Wishbone cycle
- STB_O  output  1  Wishbone strobe
- WE_O  output  1  Wishbone write enable
- ADR_O  output  32  Wishbone address
- DAT_O  output  32  Wishbone write data
- SEL_O  output  4  Wishbone byte select
- DAT_I  input  32  Wishbone read data
- ACK_I  input  1  Wishbone acknowledge

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values:
  - state = IDLE.
  - CYC_O, STB_O, WE_O = 0; ADR_O, DAT_O = 0; SEL_O = 0.
  - ExtData_out = 0; timeout_err = 0; timeout counter = 0.
  - busy_o = 0, unless rwi_in is valid during reset. busy_o is combinational from state and rwi_in, so it may be 1 in that case.
- States: IDLE, BUS, DONE.
- IDLE:
  - If rwi_in is 01 or 10, busy_o = 1 combinationally in the same cycle.
  - Next edge: latch addr_in into ADR_O, writeData_in into DAT_O, and (rwi_in==01) into WE_O.
  - Same edge: set SEL_O=4'hF and CYC_O=STB_O=1, clear the counter, go to BUS.
  - If rwi_in is 00 or 11: busy_o = 0, state stays IDLE.
- BUS:
  - busy_o = 1. CYC_O, STB_O, ADR_O, DAT_O, WE_O and SEL_O are held stable.
  - Changes on rwi_in, addr_in and writeData_in are ignored.
  - ACK_I=1 at an edge:
    - Drop CYC_O and STB_O; clear WE_O and SEL_O.
    - If the request was a read, register DAT_I into ExtData_out.
    - Go to DONE.
  - Else, counter == TIMEOUT_CYCLES-1 at an edge:
    - Drop CYC_O and STB_O; set timeout_err=1.
    - If the request was a read, load ExtData_out=ERR_DATA.
    - Go to DONE.
  - Else: increment the counter.
  - ACK_I takes priority over timeout when both occur on the same edge.
- DONE:
  - busy_o = 0 for exactly one cycle. ExtData_out is valid for this cycle.
  - rwi_in is ignored in this cycle. Go to IDLE unconditionally.
  - Requester contract: MMIO/CPU must drop or change its request during DONE. A request still present in the following IDLE cycle is treated as a new transaction.
- ExtData_out:
  - Holds its value between transactions.
  - Writes never modify it.
  - Changes only on read completion or reset.
- Timing:
  - Minimum latency, request to busy low: 2 cycles (IDLE→BUS, ACK in the first BUS cycle →DONE).
  - Throughput: one transaction per 3 cycles at best.
- ACK_I seen in IDLE or DONE: ignored, no state change.
- Reset mid-operation:
  - rst asserted in BUS or DONE forces IDLE on that edge and clears CYC_O/STB_O immediately.
  - No Wishbone completion is reported.
- timeout_err: cleared only by rst.

Test Plan:
- Read, zero-wait: rwi_in=10, addr_in=32'h33000420; ACK_I=1 with DAT_I=32'h12345678 on the first BUS cycle.
  - Expect: busy_o=1 for cycles 0–1; CYC/STB high for 1 cycle; WE_O=0; SEL_O=F.
  - Expect in cycle 2: DONE with busy_o=0 and ExtData_out=32'h12345678.
- Write with 3 wait states: rwi_in=01, addr=32'h33000500, data=32'hCAFEF00D.
  - Expect: ADR_O/DAT_O stable, WE_O=1 throughout BUS; BUS lasts 4 cycles.
  - Expect: ExtData_out unchanged from its previous value afterwards.
- Timeout: TIMEOUT_CYCLES=4, read with ACK_I held 0.
  - Expect: CYC drops after 4 BUS cycles; ExtData_out=32'hDEADBEEF; timeout_err=1 and still 1 after a later successful read.
  - Expect: ACK_I on the 4th BUS cycle completes normally, with timeout_err=0.
- Request held through DONE: keep rwi_in=10 constant.
  - Expect: DONE ignores it, then a second transaction starts from IDLE.
  - Expect: rwi_in changing during BUS has no effect on ADR_O or WE_O.
- Reset mid-BUS: assert rst in the 2nd BUS cycle.
  - Expect at the next edge: CYC_O=STB_O=0, state IDLE, busy_o=0 with rwi_in=11.
  - Expect: a late ACK_I afterwards is ignored.
- Idle encodings: rwi_in=00 and 11 for 10 cycles.
  - Expect: CYC_O never asserts, busy_o=0.

Source files
------------

// File: rtl/t07_wb_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : t07_wb_mem_bridge
// Purpose  : Responder for the MMIO instruction/data-memory request port.
//            Turns an MMIO rwi/address/data request into one Wishbone classic
//            cycle. It returns the read data and a busy handshake. A bus
//            timeout stops a stalled slave from hanging the CPU.
// Ports    : clk, rst             - clock, synchronous active-high reset
//            rwi_in               - 01 write, 10 read, 00/11 idle
//            addr_in/writeData_in - request address / write data
//            busy_o               - transaction in progress (combinational)
//            ExtData_out          - read data, valid in the DONE cycle
//            timeout_err          - sticky bus-timeout flag
//            CYC_O..SEL_O, DAT_I, ACK_I - Wishbone master side
// Revision : 1.0 - initial release
// ============================================================================
module t07_wb_mem_bridge #(
  parameter int unsigned  TIMEOUT_CYCLES = 255,
  parameter logic [31:0]  ERR_DATA       = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  rwi_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] writeData_in,
  output logic        busy_o,
  output logic [31:0] ExtData_out,
  output logic        timeout_err,
  output logic        CYC_O,
  output logic        STB_O,
  output logic        WE_O,
  output logic [31:0] ADR_O,
  output logic [31:0] DAT_O,
  output logic [3:0]  SEL_O,
  input  logic [31:0] DAT_I,
  input  logic        ACK_I
);

  // Counter value on the edge that ends the last allowed BUS cycle.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [15:0] cnt;
  logic        req_valid;
  logic        timeout_hit;

  assign req_valid   = (rwi_in == 2'b01) || (rwi_in == 2'b10);
  assign timeout_hit = (cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy_o     = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          busy_o     = 1'b1;
          state_next = BUS;
        end
      end
      BUS: begin
        busy_o = 1'b1;
        if (ACK_I || timeout_hit) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Wishbone outputs, result data and timeout bookkeeping. WE_O stays valid
  // for the whole BUS state, so it doubles as the read/write flag on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      CYC_O       <= 1'b0;
      STB_O       <= 1'b0;
      WE_O        <= 1'b0;
      ADR_O       <= 32'd0;
      DAT_O       <= 32'd0;
      SEL_O       <= 4'h0;
      ExtData_out <= 32'd0;
      timeout_err <= 1'b0;
      cnt         <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            ADR_O <= addr_in;
            DAT_O <= writeData_in;
            WE_O  <= (rwi_in == 2'b01);
            SEL_O <= 4'hF;
            CYC_O <= 1'b1;
            STB_O <= 1'b1;
            cnt   <= 16'd0;
          end
        end
        BUS: begin
          if (ACK_I) begin
            CYC_O <= 1'b0;
            STB_O <= 1'b0;
            WE_O  <= 1'b0;
            SEL_O <= 4'h0;
            if (!WE_O) ExtData_out <= DAT_I;
          end else if (timeout_hit) begin
            CYC_O       <= 1'b0;
            STB_O       <= 1'b0;
            WE_O        <= 1'b0;
            SEL_O       <= 4'h0;
            timeout_err <= 1'b1;
            if (!WE_O) ExtData_out <= ERR_DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_t07_wb_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_t07_wb_mem_bridge
// Purpose  : Self-checking bench for t07_wb_mem_bridge (TIMEOUT_CYCLES=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_t07_wb_mem_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  rwi_in = 2'b00;
  logic [31:0] addr_in = 32'd0;
  logic [31:0] writeData_in = 32'd0;
  logic        busy_o;
  logic [31:0] ExtData_out;
  logic        timeout_err;
  logic        CYC_O, STB_O, WE_O;
  logic [31:0] ADR_O, DAT_O;
  logic [3:0]  SEL_O;
  logic [31:0] DAT_I = 32'd0;
  logic        ACK_I = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  t07_wb_mem_bridge #(.TIMEOUT_CYCLES(4), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .rst(rst), .rwi_in(rwi_in), .addr_in(addr_in),
    .writeData_in(writeData_in), .busy_o(busy_o), .ExtData_out(ExtData_out),
    .timeout_err(timeout_err), .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O),
    .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O), .DAT_I(DAT_I), .ACK_I(ACK_I)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  rwi;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] dat;
    logic        busy;
    logic        cyc;
    logic        we;
    logic [3:0]  sel;
    logic        chk_ws;
    logic [31:0] adr;
    logic [31:0] dato;
    logic [31:0] ext;
    logic        terr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic [1:0] rwi, input logic [31:0] a,
                     input logic [31:0] wd, input logic ack, input logic [31:0] d,
                     input logic busy, input logic cyc, input logic we,
                     input logic [3:0] sel, input logic chk_ws, input logic [31:0] adr,
                     input logic [31:0] dato, input logic [31:0] ext, input logic terr);
    vec_t v;
    v.rst = r; v.rwi = rwi; v.addr = a; v.wdata = wd; v.ack = ack; v.dat = d;
    v.busy = busy; v.cyc = cyc; v.we = we; v.sel = sel; v.chk_ws = chk_ws;
    v.adr = adr; v.dato = dato; v.ext = ext; v.terr = terr;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;

    // ---------------- vector table ----------------
    // reset state, and combinational busy with a valid request during reset
    add(1, 2'b00, 0, 0, 0, 0,                       0, 0, 0, 4'h0, 1, 0, 0, 0, 0);
    add(1, 2'b10, 32'h11111111, 0, 0, 0,            1, 0, 0, 4'h0, 1, 0, 0, 0, 0);
    // read, zero-wait
    add(0, 2'b10, 32'h33000420, 0, 0, 0,            1, 0, 0, 4'h0, 1, 0, 0, 0, 0);
    add(0, 2'b00, 0, 0, 1, 32'h12345678,            1, 1, 0, 4'hF, 1, 32'h33000420, 0, 0, 0);
    add(0, 2'b00, 0, 0, 0, 0,                       0, 0, 0, 4'h0, 1, 32'h33000420, 0, 32'h12345678, 0);
    // write, 3 wait states; ACK on the 4th BUS cycle coincides with the timeout edge
    add(0, 2'b01, 32'h33000500, 32'hCAFEF00D, 0, 0, 1, 0, 0, 4'h0, 1, 32'h33000420, 0, 32'h12345678, 0);
    add(0, 2'b00, 0, 0, 0, 0,                       1, 1, 1, 4'hF, 1, 32'h33000500, 32'hCAFEF00D, 32'h12345678, 0);
    add(0, 2'b10, 32'hFFFFFFFF, 0, 0, 0,            1, 1, 1, 4'hF, 1, 32'h33000500, 32'hCAFEF00D, 32'h12345678, 0);
    add(0, 2'b11, 0, 0, 0, 0,                       1, 1, 1, 4'hF, 1, 32'h33000500, 32'hCAFEF00D, 32'h12345678, 0);
    add(0, 2'b00, 0, 0, 1, 32'hAAAAAAAA,            1, 1, 1, 4'hF, 1, 32'h33000500, 32'hCAFEF00D, 32'h12345678, 0);
    add(0, 2'b00, 0, 0, 0, 0,                       0, 0, 0, 4'h0, 1, 32'h33000500, 32'hCAFEF00D, 32'h12345678, 0);
    // read request held through DONE, then a second transaction
    add(0, 2'b10, 32'h33000600, 0, 0, 0,            1, 0, 0, 4'h0, 1, 32'h33000500, 32'hCAFEF00D, 32'h12345678, 0);
    add(0, 2'b10, 32'h33000600, 0, 1, 32'h0000BEEF, 1, 1, 0, 4'hF, 1, 32'h33000600, 0, 32'h12345678, 0);
    add(0, 2'b10, 32'h33000600, 0, 0, 0,            0, 0, 0, 4'h0, 1, 32'h33000600, 0, 32'h0000BEEF, 0);
    add(0, 2'b10, 32'h33000604, 0, 0, 0,            1, 0, 0, 4'h0, 1, 32'h33000600, 0, 32'h0000BEEF, 0);
    add(0, 2'b01, 0, 0, 1, 32'h11112222,            1, 1, 0, 4'hF, 1, 32'h33000604, 0, 32'h0000BEEF, 0);
    add(0, 2'b00, 0, 0, 0, 0,                       0, 0, 0, 4'h0, 1, 32'h33000604, 0, 32'h11112222, 0);
    // read timeout (4 BUS cycles, no ACK)
    add(0, 2'b10, 32'h33000700, 0, 0, 0,            1, 0, 0, 4'h0, 1, 32'h33000604, 0, 32'h11112222, 0);
    for (int i = 0; i < 4; i++)
      add(0, 2'b00, 0, 0, 0, 32'h55555555,          1, 1, 0, 4'hF, 1, 32'h33000700, 0, 32'h11112222, 0);
    add(0, 2'b00, 0, 0, 0, 0,                       0, 0, 0, 4'h0, 0, 32'h33000700, 0, 32'hDEADBEEF, 1);
    // later successful read keeps the sticky flag
    add(0, 2'b10, 32'h33000800, 0, 0, 0,            1, 0, 0, 4'h0, 0, 32'h33000700, 0, 32'hDEADBEEF, 1);
    add(0, 2'b00, 0, 0, 1, 32'h87654321,            1, 1, 0, 4'hF, 1, 32'h33000800, 0, 32'hDEADBEEF, 1);
    add(0, 2'b00, 0, 0, 0, 0,                       0, 0, 0, 4'h0, 1, 32'h33000800, 0, 32'h87654321, 1);
    // idle encodings with stray ACK
    for (int i = 0; i < 10; i++)
      add(0, (i % 2 == 1) ? 2'b11 : 2'b00, 0, 0, 1, 0,
                                                    0, 0, 0, 4'h0, 1, 32'h33000800, 0, 32'h87654321, 1);
    // reset in the 2nd BUS cycle of a write, then a late ACK
    add(0, 2'b01, 32'h33000900, 32'h0A0A0A0A, 0, 0, 1, 0, 0, 4'h0, 1, 32'h33000800, 0, 32'h87654321, 1);
    add(0, 2'b00, 0, 0, 0, 0,                       1, 1, 1, 4'hF, 1, 32'h33000900, 32'h0A0A0A0A, 32'h87654321, 1);
    add(1, 2'b00, 0, 0, 0, 0,                       1, 1, 1, 4'hF, 1, 32'h33000900, 32'h0A0A0A0A, 32'h87654321, 1);
    add(0, 2'b11, 0, 0, 1, 0,                       0, 0, 0, 4'h0, 1, 0, 0, 0, 0);
    add(0, 2'b00, 0, 0, 1, 0,                       0, 0, 0, 4'h0, 1, 0, 0, 0, 0);

    // ---------------- apply ----------------
    rst = 1'b1;
    step();
    step();
    foreach (vq[i]) begin
      rst = vq[i].rst; rwi_in = vq[i].rwi; addr_in = vq[i].addr;
      writeData_in = vq[i].wdata; ACK_I = vq[i].ack; DAT_I = vq[i].dat;
      #1;
      chk("busy", i, 32'(busy_o), 32'(vq[i].busy));
      chk("cyc",  i, 32'(CYC_O),  32'(vq[i].cyc));
      chk("stb",  i, 32'(STB_O),  32'(vq[i].cyc));
      if (vq[i].chk_ws) begin
        chk("we",  i, 32'(WE_O),  32'(vq[i].we));
        chk("sel", i, 32'(SEL_O), 32'(vq[i].sel));
      end
      chk("adr",  i, ADR_O, vq[i].adr);
      chk("dato", i, DAT_O, vq[i].dato);
      chk("ext",  i, ExtData_out, vq[i].ext);
      chk("terr", i, 32'(timeout_err), 32'(vq[i].terr));
      step();
    end

    // ---------------- hand sequence: timeout length measured on the bus ----------------
    rst = 1'b0; ACK_I = 1'b0; DAT_I = 32'h0;
    rwi_in = 2'b10; addr_in = 32'h33000A00;
    step();
    rwi_in = 2'b00;
    n = 0;
    while (CYC_O === 1'b1 && n < 20) begin
      n++;
      step();
    end
    chk("to_len", 1000, 32'(n), 32'd4);
    chk("to_busy", 1000, 32'(busy_o), 32'd0);
    chk("to_ext", 1000, ExtData_out, 32'hDEADBEEF);
    chk("to_terr", 1000, 32'(timeout_err), 32'd1);
    step();
    chk("to_idle_cyc", 1001, 32'(CYC_O), 32'd0);
    chk("to_idle_terr", 1001, 32'(timeout_err), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
